// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types for the two-requester RAM port arbiter.
//   ram_req_t   : one requester's view of the ram_* port (strobes, read,
//                 address, write data, burst-lock hint)
//   REQ_NONE    : idle request; the muxed RAM outputs fall back to it when
//                 nobody is granted
//   req_active  : a request is present when it reads or has any write strobe
package ram_arb_pkg;

    typedef struct packed {
        logic [3:0]  wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } ram_req_t;

    localparam ram_req_t REQ_NONE = '0;

    function automatic logic req_active(input ram_req_t r);
        return r.rd | (|r.wr);
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2
// Two-way round-robin grant with burst locking and a hold-count cap.
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   req_i[1:0]      : per-requester request present
//   lock_i[1:0]     : per-requester "more beats of this burst follow"
//   ram_accept_i    : RAM takes the granted request this cycle
//   grant_o[1:0]    : one-hot (or zero) combinational grant
//   xfer_o[1:0]     : grant qualified by request and RAM accept
module ram_arb_rr2 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       ram_accept_i,
    output logic [1:0] grant_o,
    output logic [1:0] xfer_o
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             prio_reg,  prio_next;
    logic             lock_reg,  lock_next;
    logic             owner_reg, owner_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic       honour_lock;
    logic [1:0] grant;
    logic [1:0] xfer;
    logic       xfer_idx;

    // The lock only counts while its owner is still asking and has not used
    // up its hold budget; otherwise it lapses and plain round-robin applies.
    assign honour_lock = lock_reg & req_i[owner_reg] & (hold_cnt_reg < HOLD_MAX);

    always_comb begin
        grant = 2'b00;
        if (honour_lock) begin
            grant[owner_reg] = 1'b1;
        end else if (&req_i) begin
            grant[prio_reg] = 1'b1;
        end else begin
            // zero or exactly one requester: grant it directly
            grant = req_i;
        end
    end

    assign xfer     = grant & req_i & {2{ram_accept_i}};
    assign xfer_idx = xfer[1];
    assign grant_o  = grant;
    assign xfer_o   = xfer;

    always_comb begin
        prio_next     = prio_reg;
        lock_next     = lock_reg;
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        if (|xfer) begin
            prio_next = ~xfer_idx;
            lock_next = lock_i[xfer_idx];
            if (lock_reg && (owner_reg == xfer_idx)) begin
                // continuing a locked burst: count beats, saturating at the cap
                if (hold_cnt_reg < HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + CNT_ONE;
                end
            end else begin
                owner_next    = xfer_idx;
                hold_cnt_next = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_reg     <= 1'b0;
            lock_reg     <= 1'b0;
            owner_reg    <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            prio_reg     <= prio_next;
            lock_reg     <= lock_next;
            owner_reg    <= owner_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port SRAM interface between two AXI-to-RAM bridges.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   mN_wr_i/rd_i/addr_i/wdata_i/lock_i : requester N request (N = 0, 1)
//   mN_accept_o          : requester N request taken this cycle
//   mN_rdata_o/rvalid_o  : read data returned one cycle after a read accept
//   ram_wr_o/rd_o/addr_o/write_data_o  : request forwarded to the RAM
//   ram_read_data_i      : RAM read data, valid the cycle after a read accept
//   ram_accept_i         : RAM takes the request this cycle
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [3:0]  m0_wr_i,
    input  logic        m0_rd_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m0_lock_i,
    output logic        m0_accept_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rvalid_o,

    input  logic [3:0]  m1_wr_i,
    input  logic        m1_rd_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m1_accept_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rvalid_o,

    output logic [3:0]  ram_wr_o,
    output logic        ram_rd_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_write_data_o,
    input  logic [31:0] ram_read_data_i,
    input  logic        ram_accept_i
);

    ram_req_t   req_arr [2];
    logic [1:0] req_vec;
    logic [1:0] lock_vec;
    logic [1:0] grant;
    logic [1:0] xfer;
    logic [1:0] accept_vec;
    logic [1:0] rvalid_vec;

    logic rd_pend_reg,  rd_pend_next;
    logic rd_owner_reg, rd_owner_next;

    assign req_arr[0] = '{wr: m0_wr_i, rd: m0_rd_i, addr: m0_addr_i,
                          wdata: m0_wdata_i, lock: m0_lock_i};
    assign req_arr[1] = '{wr: m1_wr_i, rd: m1_rd_i, addr: m1_addr_i,
                          wdata: m1_wdata_i, lock: m1_lock_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_vec[gi]    = req_active(req_arr[gi]);
            assign lock_vec[gi]   = req_arr[gi].lock;
            assign accept_vec[gi] = grant[gi] & ram_accept_i;
            assign rvalid_vec[gi] = rd_pend_reg & (rd_owner_reg == 1'(gi));
        end
    endgenerate

    ram_arb_rr2 #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_rr2 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_vec),
        .lock_i       (lock_vec),
        .ram_accept_i (ram_accept_i),
        .grant_o      (grant),
        .xfer_o       (xfer)
    );

    // Forward the granted request in the same cycle; idle fields otherwise.
    always_comb begin
        ram_wr_o         = REQ_NONE.wr;
        ram_rd_o         = REQ_NONE.rd;
        ram_addr_o       = REQ_NONE.addr;
        ram_write_data_o = REQ_NONE.wdata;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                ram_wr_o         = req_arr[i].wr;
                ram_rd_o         = req_arr[i].rd;
                ram_addr_o       = req_arr[i].addr;
                ram_write_data_o = req_arr[i].wdata;
            end
        end
    end

    assign m0_accept_o = accept_vec[0];
    assign m1_accept_o = accept_vec[1];

    // Read return: remember which requester issued the read the RAM just took,
    // so next cycle's RAM data can be tagged back to it.
    always_comb begin
        rd_pend_next  = 1'b0;
        rd_owner_next = rd_owner_reg;
        if (|xfer) begin
            rd_pend_next  = req_arr[xfer[1]].rd;
            if (req_arr[xfer[1]].rd) begin
                rd_owner_next = xfer[1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else begin
            rd_pend_reg  <= rd_pend_next;
            rd_owner_reg <= rd_owner_next;
        end
    end

    // Data is broadcast; rvalid says whose it is.
    assign m0_rdata_o  = ram_read_data_i;
    assign m1_rdata_o  = ram_read_data_i;
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic [3:0]  m0_wr_i, m1_wr_i;
    logic        m0_rd_i, m1_rd_i;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic        m0_lock_i, m1_lock_i;
    logic        m0_accept_o, m1_accept_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [3:0]  ram_wr_o;
    logic        ram_rd_o;
    logic [31:0] ram_addr_o, ram_write_data_o;
    logic [31:0] ram_read_data_i;
    logic        ram_accept_i;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .m0_wr_i          (m0_wr_i),
        .m0_rd_i          (m0_rd_i),
        .m0_addr_i        (m0_addr_i),
        .m0_wdata_i       (m0_wdata_i),
        .m0_lock_i        (m0_lock_i),
        .m0_accept_o      (m0_accept_o),
        .m0_rdata_o       (m0_rdata_o),
        .m0_rvalid_o      (m0_rvalid_o),
        .m1_wr_i          (m1_wr_i),
        .m1_rd_i          (m1_rd_i),
        .m1_addr_i        (m1_addr_i),
        .m1_wdata_i       (m1_wdata_i),
        .m1_lock_i        (m1_lock_i),
        .m1_accept_o      (m1_accept_o),
        .m1_rdata_o       (m1_rdata_o),
        .m1_rvalid_o      (m1_rvalid_o),
        .ram_wr_o         (ram_wr_o),
        .ram_rd_o         (ram_rd_o),
        .ram_addr_o       (ram_addr_o),
        .ram_write_data_o (ram_write_data_o),
        .ram_read_data_i  (ram_read_data_i),
        .ram_accept_i     (ram_accept_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_wr_i = 4'h0; m0_rd_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_lock_i = 1'b0;
        m1_wr_i = 4'h0; m1_rd_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_lock_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        ram_accept_i    = 1'b1;
        ram_read_data_i = '0;

        // reset state
        tick(); tick(); #2;
        $display("reset state");
        check("rst_m0_accept", 32'(m0_accept_o), 32'd0);
        check("rst_m1_accept", 32'(m1_accept_o), 32'd0);
        check("rst_ram_rd",    32'(ram_rd_o),    32'd0);
        check("rst_ram_wr",    32'(ram_wr_o),    32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid_o), 32'd0);

        tick();
        rst_i = 1'b0;

        // contention without lock: m0, m1, m0, m1
        for (int i = 0; i < 4; i++) begin
            tick();
            m0_rd_i = 1'b1; m0_addr_i = 32'h10;
            m1_rd_i = 1'b1; m1_addr_i = 32'h20;
            ram_read_data_i = 32'h1000 + 32'(i);
            #2;
            $display("contention beat %0d: acc0=%0b acc1=%0b addr=%h", i, m0_accept_o, m1_accept_o, ram_addr_o);
            check("cont_acc0", 32'(m0_accept_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_acc1", 32'(m1_accept_o), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("cont_addr", ram_addr_o, (i % 2 == 0) ? 32'h10 : 32'h20);
            if (i > 0) begin
                check("cont_rv0", 32'(m0_rvalid_o), (i % 2 == 1) ? 32'd1 : 32'd0);
                check("cont_rv1", 32'(m1_rvalid_o), (i % 2 == 0) ? 32'd1 : 32'd0);
                check("cont_rdata", m0_rdata_o, 32'h1000 + 32'(i));
            end
        end
        tick();
        idle();
        ram_read_data_i = 32'h1004;
        #2;
        $display("contention tail: rv1=%0b rdata=%h", m1_rvalid_o, m1_rdata_o);
        check("tail_rv1",   32'(m1_rvalid_o), 32'd1);
        check("tail_rv0",   32'(m0_rvalid_o), 32'd0);
        check("tail_rdata", m1_rdata_o, 32'h1004);
        check("idle_ram_rd",   32'(ram_rd_o), 32'd0);
        check("idle_ram_addr", ram_addr_o, 32'h0);

        // single read by m0
        tick();
        m0_rd_i = 1'b1; m0_addr_i = 32'h100;
        #2;
        $display("single read: acc0=%0b ram_rd=%0b addr=%h", m0_accept_o, ram_rd_o, ram_addr_o);
        check("sr_acc0",  32'(m0_accept_o), 32'd1);
        check("sr_acc1",  32'(m1_accept_o), 32'd0);
        check("sr_ramrd", 32'(ram_rd_o), 32'd1);
        check("sr_addr",  ram_addr_o, 32'h100);
        tick();
        idle();
        ram_read_data_i = 32'hDEADBEEF;
        #2;
        $display("single read return: rv0=%0b rdata=%h rv1=%0b", m0_rvalid_o, m0_rdata_o, m1_rvalid_o);
        check("sr_rv0",   32'(m0_rvalid_o), 32'd1);
        check("sr_rdata", m0_rdata_o, 32'hDEADBEEF);
        check("sr_rv1",   32'(m1_rvalid_o), 32'd0);

        // single m1 write, leaves priority with m0
        tick();
        m1_wr_i = 4'hF; m1_addr_i = 32'h200; m1_wdata_i = 32'h11112222;
        #2;
        $display("m1 write: acc1=%0b wr=%h wdata=%h", m1_accept_o, ram_wr_o, ram_write_data_o);
        check("w1_acc1",  32'(m1_accept_o), 32'd1);
        check("w1_wr",    32'(ram_wr_o), 32'hF);
        check("w1_wdata", ram_write_data_o, 32'h11112222);

        // burst lock: m0 four beats lock=1,1,1,0 while m1 waits
        for (int i = 0; i < 5; i++) begin
            tick();
            idle();
            m1_wr_i = 4'hF; m1_addr_i = 32'h208; m1_wdata_i = 32'h33334444;
            if (i < 4) begin
                m0_wr_i = 4'hF; m0_addr_i = 32'h180 + 32'(4 * i);
                m0_wdata_i = 32'hA0 + 32'(i); m0_lock_i = (i < 3);
            end
            #2;
            $display("burst beat %0d: acc0=%0b acc1=%0b addr=%h", i, m0_accept_o, m1_accept_o, ram_addr_o);
            check("burst_acc0", 32'(m0_accept_o), (i < 4) ? 32'd1 : 32'd0);
            check("burst_acc1", 32'(m1_accept_o), (i == 4) ? 32'd1 : 32'd0);
            check("burst_addr", ram_addr_o, (i < 4) ? 32'h180 + 32'(4 * i) : 32'h208);
        end

        // hold limit (MAX_HOLD=4): m0 holds lock, m1 waits
        for (int i = 0; i < 6; i++) begin
            tick();
            idle();
            m0_wr_i = 4'hF; m0_addr_i = 32'h500; m0_lock_i = 1'b1;
            m1_wr_i = 4'hF; m1_addr_i = 32'h600;
            #2;
            $display("hold beat %0d: acc0=%0b acc1=%0b", i, m0_accept_o, m1_accept_o);
            check("hold_acc0", 32'(m0_accept_o), (i == 4) ? 32'd0 : 32'd1);
            check("hold_acc1", 32'(m1_accept_o), (i == 4) ? 32'd1 : 32'd0);
        end

        // backpressure on m1 write; m0 lock lapses because m0 stops asking
        tick();
        idle();
        m1_wr_i = 4'hF; m1_addr_i = 32'h300; m1_wdata_i = 32'hCAFEF00D;
        ram_accept_i = 1'b0;
        #2;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                tick();
                #2;
            end
            $display("stall %0d: acc1=%0b wr=%h", j, m1_accept_o, ram_wr_o);
            check("bp_acc1", 32'(m1_accept_o), 32'd0);
            check("bp_acc0", 32'(m0_accept_o), 32'd0);
            check("bp_wr",   32'(ram_wr_o), 32'hF);
        end
        tick();
        ram_accept_i = 1'b1;
        #2;
        $display("stall release: acc1=%0b addr=%h wdata=%h", m1_accept_o, ram_addr_o, ram_write_data_o);
        check("bp_done_acc1",  32'(m1_accept_o), 32'd1);
        check("bp_done_addr",  ram_addr_o, 32'h300);
        check("bp_done_wdata", ram_write_data_o, 32'hCAFEF00D);

        // read accepted, then async reset asserted the next cycle
        tick();
        idle();
        m0_rd_i = 1'b1; m0_addr_i = 32'h400;
        #2;
        $display("pre-reset read: acc0=%0b", m0_accept_o);
        check("prerst_acc0", 32'(m0_accept_o), 32'd1);
        tick();
        rst_i = 1'b1;
        idle();
        ram_read_data_i = '0;
        #2;
        $display("in reset: rv0=%0b rv1=%0b ram_rd=%0b", m0_rvalid_o, m1_rvalid_o, ram_rd_o);
        check("inrst_rv0",   32'(m0_rvalid_o), 32'd0);
        check("inrst_rv1",   32'(m1_rvalid_o), 32'd0);
        check("inrst_rd",    32'(ram_rd_o), 32'd0);
        check("inrst_wr",    32'(ram_wr_o), 32'd0);
        check("inrst_addr",  ram_addr_o, 32'h0);
        check("inrst_wdata", ram_write_data_o, 32'h0);
        check("inrst_acc0",  32'(m0_accept_o), 32'd0);
        check("inrst_acc1",  32'(m1_accept_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        m0_rd_i = 1'b1; m0_addr_i = 32'h10;
        m1_rd_i = 1'b1; m1_addr_i = 32'h20;
        #2;
        $display("post-reset contention: acc0=%0b acc1=%0b", m0_accept_o, m1_accept_o);
        check("postrst_acc0", 32'(m0_accept_o), 32'd1);
        check("postrst_acc1", 32'(m1_accept_o), 32'd0);
        tick();
        idle();
        ram_read_data_i = 32'h55AA55AA;
        #2;
        $display("post-reset return: rv0=%0b rdata=%h", m0_rvalid_o, m0_rdata_o);
        check("postrst_rv0", 32'(m0_rvalid_o), 32'd1);
        check("postrst_rv1", 32'(m1_rvalid_o), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter that shares one single-port SRAM interface, the ram_* word/byte-strobe port driven by the AXI-to-RAM bridges. Typical use: the instruction-fetch bridge and the data bridge sharing one on-chip RAM.
Arbitration is round-robin, with optional burst locking so a bridge's AXI burst stays contiguous. A hold counter caps how long one requester can keep the lock. Read data is returned one cycle after acceptance and tagged to the requester that issued the read.

Parameters:
MAX_HOLD, 16, maximum consecutive locked transfers by one owner before the lock is ignored (range 1..255)
CNT_W, 8, width of hold counter (must hold MAX_HOLD)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m0_wr_i  in  4  requester 0 byte write strobes (non-zero = write)
m0_rd_i  in  1  requester 0 read request
m0_addr_i  in  32  requester 0 byte address
m0_wdata_i  in  32  requester 0 write data
m0_lock_i  in  1  requester 0: more beats of this burst follow
m0_accept_o  out  1  requester 0 request accepted this cycle
m0_rdata_o  out  32  requester 0 read data
m0_rvalid_o  out  1  requester 0 read data valid
m1_*  —  —  identical set for requester 1
ram_wr_o  out  4  RAM byte write strobes
ram_rd_o  out  1  RAM read
ram_addr_o  out  32  RAM address
ram_write_data_o  out  32  RAM write data
ram_read_data_i  in  32  RAM read data (valid cycle after accepted read)
ram_accept_i  in  1  RAM accepts request this cycle

Behaviour:
- Request and transfer
  - reqN = mN_rd_i | (|mN_wr_i).
  - xferN = grantN & reqN & ram_accept_i.
  - mN_accept_o = grantN & ram_accept_i, combinational, no added latency.
  - A requester must hold its request stable until its accept is seen.
- State registers
  - prio_q: next round-robin winner; reset 0.
  - lock_q, owner_q, hold_cnt_q: reset 0, 0, 0.
  - rd_pend_q, rd_owner_q: reset 0, 0.
- Grant selection (combinational, one-hot, at most one grant)
  - Lock honoured: if lock_q & req[owner_q] & (hold_cnt_q < MAX_HOLD), grant owner_q.
  - Else if both request, grant prio_q.
  - Else grant the single requester.
  - Else no grant.
- RAM outputs
  - Muxed from the granted requester.
  - ram_wr_o = 0 and ram_rd_o = 0 when there is no grant.
  - ram_addr_o and ram_write_data_o = 0 when there is no grant.
  - Requests are forwarded to the RAM in the same cycle they are granted.
- On any transfer by requester N
  - prio_q <= ~N (the other requester gets priority next).
  - If N == owner_q & lock_q: hold_cnt_q <= saturating +1.
  - Otherwise: owner_q <= N and hold_cnt_q <= 1.
  - lock_q <= mN_lock_i.
  - The hold counter is only compared while the lock is honoured.
- Lock lapse
  - Owner not requesting while lock_q is set: lock lapses. The other requester may be granted.
  - That cycle's transfer (if any) is by the other requester, which overwrites owner_q and lock_q.
- Hold-limit expiry: once hold_cnt_q reaches MAX_HOLD, arbitration is plain round-robin.
  - A waiting requester wins the next cycle because prio_q already points to it.
  - If nobody else requests, the owner continues. The counter saturates and resets to 1 when ownership changes.
- Read return
  - On a read transfer: rd_pend_q <= 1 and rd_owner_q <= N. Otherwise rd_pend_q <= 0.
  - mN_rvalid_o = rd_pend_q & (rd_owner_q == N).
  - mN_rdata_o = ram_read_data_i, broadcast to both requesters and qualified by rvalid.
  - Back-to-back reads from alternating requesters are supported at one per cycle.
- Simultaneous rd and wr from one requester: treated as one request, both forwarded unchanged. Callers must not do this.
- Reset mid-operation clears lock, priority and pending read. A read accepted in the reset cycle produces no rvalid.
- No transfer occurs while ram_accept_i = 0. State holds, and the grant may change as requests change.

Decomposition:
- Package ram_arb_pkg: request struct fields (wr strobe, rd, addr, wdata, lock) and localparam REQ_NONE.
- One natural sub-module: ram_arb_rr2, the two-way round-robin/lock grant logic with prio, lock, owner and hold counter.
- The top level holds the mux and read-return tagging.

Test Plan:
- Single read: m0 rd addr 0x100, ram returns 0xDEADBEEF -> m0_accept_o=1 in the same cycle; next cycle m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF; m1_rvalid_o=0.
- Contention without lock: m0 and m1 read every cycle, accept=1 -> grants alternate m0,m1,m0,m1 starting with m0 after reset; rvalid tags alternate to match.
- Burst lock: m0 issues 4 writes with lock=1,1,1,0 while m1 requests throughout -> m0 gets 4 consecutive accepts, then m1 is granted on cycle 5.
- Hold limit: MAX_HOLD=4, m0 keeps lock=1 for 10 beats with m1 waiting -> m0 gets 4 accepts, m1 gets the 5th-cycle grant, then m0 resumes.
- Backpressure: ram_accept_i=0 for 3 cycles during an m1 write wstrb=0xF -> no accept and no state change; the write completes on the first accept=1 cycle with correct addr/data.
- Async reset asserted one cycle after an accepted read -> no rvalid; all outputs 0; first post-reset contention grants m0.
